// File: rtl/clk_period_meter.sv
// Measures the period (and, with CLK_PERIOD_METER_DUTY_EN, the high time) of an async input in clk_i cycles.
// Latency: valid_o/period_o/high_o update SYNC_STAGES+1 clk_i edges after the closing sig_i rising edge.
// No backpressure: valid_o is a one-cycle pulse; timeout_o is sticky until the next valid_o.
module clk_period_meter #(
  parameter int CNT_W       = 18,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 200000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_s;
  logic                   sig_p;
  logic                   rise;
  logic [CNT_W-1:0]       cnt_q;
  logic                   load;
  logic                   run;
  logic                   capture;
  logic                   expire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      sig_p  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      sig_p  <= sig_s;
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_p;

  // A rise accepted in MEASURE outranks the timeout, so a period of exactly TIMEOUT still measures.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    run     = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          load    = 1'b1;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          load    = 1'b1;
          capture = 1'b1;
        end else if (cnt_q == TIMEOUT_C) begin
          expire  = 1'b1;
          state_d = IDLE;
        end else begin
          run = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_o  <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_o <= capture;
      if (load) begin
        cnt_q <= ONE;
      end else if (run) begin
        cnt_q <= cnt_q + ONE;
      end
      if (capture) begin
        period_o  <= cnt_q;
        timeout_o <= 1'b0;
      end else if (expire) begin
        timeout_o <= 1'b1;
      end
    end
  end

`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] high_q;

  // hcnt never exceeds cnt, so it shares the no-wrap guarantee of the period counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      if (capture) begin
        high_q <= hcnt_q;
      end
      if (load) begin
        hcnt_q <= ONE;
      end else if (run && sig_s) begin
        hcnt_q <= hcnt_q + ONE;
      end
    end
  end

  assign high_o = high_q;
`else
  assign high_o = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: directed and random square waves against a timestamp-based reference model.
module tb_clk_period_meter;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int TO    = 50;
`ifdef CLK_PERIOD_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             sig;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             timeout_o;

  int passed = 0;
  int total  = 0;

  // Reference model: sig_i samples per clk edge since reset, plus timestamps of accepted rises.
  bit hist[int];
  int e;
  bit locked;
  int last;
  int m_period, m_high, m_valid, m_to;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .sig_i    (sig),
    .period_o (period_o),
    .high_o   (high_o),
    .valid_o  (valid_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  function automatic bit hv(input int k);
    if (k >= 1 && hist.exists(k)) return hist[k];
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) begin
      passed++;
    end else begin
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    e        = 0;
    locked   = 1'b0;
    last     = 0;
    m_period = 0;
    m_high   = 0;
    m_valid  = 0;
    m_to     = 0;
  endtask

  // An input rise first sampled at edge n is acted on at edge n+SYNC, visible after it.
  task automatic model_edge();
    bit r;
    int h;
    r       = hv(e - SYNC) && !hv(e - SYNC - 1);
    m_valid = 0;
    if (r) begin
      if (locked) begin
        h = 0;
        for (int k = last - SYNC; k <= e - SYNC - 1; k++) h += int'(hv(k));
        m_period = e - last;
        m_high   = DUTY ? h : 0;
        m_valid  = 1;
        m_to     = 0;
      end
      locked = 1'b1;
      last   = e;
    end else if (locked && (e - last) == TO) begin
      m_to   = 1;
      locked = 1'b0;
    end
  endtask

  // Called at a negedge; drives sig for one cycle and checks outputs just after the posedge.
  task automatic step(input logic v);
    sig = v;
    @(posedge clk);
    e++;
    hist[e] = v;
    model_edge();
    #1;
    check("valid", {31'd0, valid_o}, m_valid);
    check("timeout", {31'd0, timeout_o}, m_to);
    check("period", {24'd0, period_o}, m_period);
    check("high", {24'd0, high_o}, m_high);
    @(negedge clk);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < hi; j++) step(1'b1);
      for (int j = 0; j < lo; j++) step(1'b0);
    end
  endtask

  // Called at a negedge; asserts rst between edges and checks the outputs clear at once.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_valid", {31'd0, valid_o}, 0);
    check("rst_timeout", {31'd0, timeout_o}, 0);
    check("rst_period", {24'd0, period_o}, 0);
    check("rst_high", {24'd0, high_o}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int h, l, n;
    model_reset();
    rst = 1'b1;
    sig = 1'b0;
    #1;
    check("init_valid", {31'd0, valid_o}, 0);
    check("init_timeout", {31'd0, timeout_o}, 0);
    check("init_period", {24'd0, period_o}, 0);
    check("init_high", {24'd0, high_o}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Period 10 / high 5, then switch to period 7 / high 2.
    wave(5, 5, 6);
    check("p10_period", {24'd0, period_o}, 10);
    wave(2, 5, 5);
    check("p7_period", {24'd0, period_o}, 7);

    // Input stops after a rise: timeout, held period, then recovery at period 10.
    step(1'b1);
    repeat (60) step(1'b0);
    check("lost_timeout", {31'd0, timeout_o}, 1);
    check("lost_hold", {24'd0, period_o}, 7);
    wave(5, 5, 4);
    check("recover_timeout", {31'd0, timeout_o}, 0);
    check("recover_period", {24'd0, period_o}, 10);

    // Boundary: period TIMEOUT measures, TIMEOUT+1 times out.
    wave(25, 25, 3);
    check("max_period", {24'd0, period_o}, 50);
    check("max_timeout", {31'd0, timeout_o}, 0);
    wave(25, 26, 3);
    check("over_timeout", {31'd0, timeout_o}, 1);

    // Random periods straddling the timeout limit.
    for (int i = 0; i < 25; i++) begin
      h = $urandom_range(1, 30);
      l = $urandom_range(1, 30);
      n = $urandom_range(1, 3);
      wave(h, l, n);
    end

    // Asynchronous reset in the middle of a period, then relock.
    wave(4, 6, 2);
    step(1'b1);
    step(1'b1);
    async_reset();
    wave(3, 6, 4);
    check("post_rst_period", {24'd0, period_o}, 9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Inverse of the design's clock dividers: measures a slow, asynchronous square wave in fast-clock cycles.
- Input is a divided clock, a display strobe, or an external pin.
- Synchronizes the input, detects rising edges, and reports the period (optionally also the high time) once per input cycle.
- Flags loss of the input with a timeout.
- Used as a self-check on divided clocks and for bring-up of scan and refresh timing.

Parameters:
- CNT_W, 18, width of the period/high-time counters and outputs.
- SYNC_STAGES, 2, number of synchronizer flops on sig_i (minimum 2).
- TIMEOUT, 200000, longest measurable period in clk_i cycles. Must satisfy TIMEOUT <= 2**CNT_W-1.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- sig_i  input  1  signal to measure, asynchronous to clk_i.
- period_o  output  CNT_W  last measured period in clk_i cycles.
- high_o  output  CNT_W  last measured high time in clk_i cycles (see Optional Feature).
- valid_o  output  1  one-cycle pulse when period_o/high_o update.
- timeout_o  output  1  sticky input-lost flag.

Behaviour:
- Reset (async, immediate, also mid-measurement):
  - All synchronizer flops, the edge-detect register, and the counters go to 0.
  - State goes to IDLE.
  - period_o=0, high_o=0, valid_o=0, timeout_o=0.
- Synchronizer and edge detect:
  - sig_i passes through SYNC_STAGES flops to give sig_s.
  - sig_p is sig_s delayed one cycle.
  - rise = sig_s & ~sig_p, a single cycle per input rising edge.
- State machine, IDLE:
  - Waits for rise.
  - On rise: cnt<=1, hcnt<=1, go to MEASURE. valid_o is not pulsed.
- State machine, MEASURE, priority order:
  - (a) rise:
    - period_o<=cnt, high_o<=hcnt, valid_o<=1, timeout_o<=0.
    - cnt<=1, hcnt<=1; stay in MEASURE.
  - (b) no rise and cnt==TIMEOUT:
    - timeout_o<=1, go to IDLE.
    - period_o and high_o hold; no valid_o.
  - (c) otherwise: cnt<=cnt+1; hcnt<=hcnt+1 if sig_s==1.
- Boundary results:
  - An input of period P cycles gives period_o=P.
  - The maximum measurable period is exactly TIMEOUT: rise in the same cycle as cnt==TIMEOUT wins.
  - A period of TIMEOUT+1 gives a timeout.
- Counters never exceed TIMEOUT, so no wrap occurs.
- Latency: valid_o and the updated period_o/high_o appear SYNC_STAGES+1 clk_i edges after the sig_i rising edge that closes the period. All outputs are registered.
- valid_o is 0 in every cycle except the one following a rise accepted in MEASURE.
- timeout_o:
  - Stays 1 through IDLE and through the first rise after recovery.
  - Clears together with the first valid_o after recovery.
- A constant-high or constant-low sig_i after lock leads to a timeout TIMEOUT cycles after the last rise.
- Pulses shorter than one clk_i cycle may be missed. This is not an error.

Optional Feature:
- Macro: CLK_PERIOD_METER_DUTY_EN.
- Defined:
  - The hcnt counter is built.
  - high_o reports the sig_s-high cycles within the measured period, counted from the rise cycle inclusive.
- Undefined:
  - No hcnt logic.
  - high_o is tied to 0.
  - All other behaviour is identical.

Test Plan:
All tests use CNT_W=8, SYNC_STAGES=2, TIMEOUT=50, with CLK_PERIOD_METER_DUTY_EN defined unless noted.
1. sig_i period 10 cycles, high 5, from reset:
   - No valid_o on the first rise.
   - On the second rise, valid_o pulses 3 edges after the sig_i edge, with period_o=10 and high_o=5.
   - Repeats every 10 cycles.
2. Switch to period 7, high 2:
   - The first complete 7-cycle period reports period_o=7, high_o=2.
   - The transitional period reports its actual length.
3. Stop toggling after a rise:
   - timeout_o=1 exactly 50 edges after the rise was accepted; no valid_o.
   - period_o holds 7.
   - Resume at period 10: the first rise gives no valid_o and timeout_o stays 1; the second rise gives valid_o, period_o=10, and timeout_o=0.
4. Period exactly 50 gives valid_o with period_o=50. Period 51 gives timeout_o=1 and no valid_o.
5. Assert rst_i asynchronously mid-period, between clk_i edges:
   - All outputs are 0 immediately.
   - After release, the first rise gives no valid_o and the second gives a correct period.
6. Rebuild without CLK_PERIOD_METER_DUTY_EN and repeat test 1: period_o=10, high_o=0.
